// File: rtl/uart_cfg_if.sv
// Host-side bundle of the configurable UART: config, TX FIFO push, RX FIFO pop, status.
// Latency: none (signal bundle only).
// Backpressure: full / empty are the flow-control indications for write_en / read_en.
//
// master: host register side. slave: uart_cfg.
interface uart_cfg_if #(
    parameter int DATA_BITS = 8,
    parameter int FIFO_AW   = 3,
    parameter int DIV_W     = 10
);
    logic [DIV_W-1:0]     baud_div;
    logic [1:0]           parity_mode;
    logic                 stop2;
    logic                 write_en;
    logic [DATA_BITS-1:0] write_data;
    logic                 full;
    logic [FIFO_AW:0]     tx_level;
    logic                 read_en;
    logic [DATA_BITS-1:0] read_data;
    logic [1:0]           rx_err;
    logic                 empty;
    logic [FIFO_AW:0]     rx_level;
    logic                 overrun;
    logic                 clr_err;
    logic                 tx_busy;

    modport master (
        output baud_div, parity_mode, stop2, write_en, write_data, read_en, clr_err,
        input  full, tx_level, read_data, rx_err, empty, rx_level, overrun, tx_busy
    );

    modport slave (
        input  baud_div, parity_mode, stop2, write_en, write_data, read_en, clr_err,
        output full, tx_level, read_data, rx_err, empty, rx_level, overrun, tx_busy
    );
endinterface

// File: rtl/uart_cfg.sv
// Configurable UART: baud tick generator, RX/TX engines with parity/stop selection, RX/TX FIFOs.
// Latency: rx pin -> RX FIFO push at mid first stop bit (+2 sync cycles); TX FIFO -> tx pin 1 cycle.
// Backpressure: writes ignored while full, reads ignored while empty; RX word dropped (overrun) when RX FIFO full.
//
// Ports: clk, rst (async active-low), bus (uart_cfg_if.slave: config, TX push, RX pop, status),
//        rx (serial in), tx (serial out). Optional macro UART_LOOPBACK_EN adds input 'loopback'
//        which feeds the internal tx into the RX synchroniser and holds the tx pin at 1.

// Generic FIFO: registered pointers/level, first-word fall-through head (zero while empty).
module uart_cfg_fifo #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_wr,
    input  logic [W-1:0] i_din,
    output logic         o_full,
    input  logic         i_rd,
    output logic [W-1:0] o_dout,
    output logic         o_empty,
    output logic [AW:0]  o_level
);
    localparam logic [AW:0] DEPTH = (AW+1)'(1) << AW;

    logic [W-1:0]  r_mem [2**AW];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_wr_ok;
    logic          w_rd_ok;

    assign o_full  = (r_level == DEPTH);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign w_wr_ok = i_wr && !o_full;
    assign w_rd_ok = i_rd && !o_empty;
    assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[r_wr_ptr] <= i_din;
    end

    // Pointers are AW bits wide so they wrap modulo the depth for free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

module uart_cfg #(
    parameter int DATA_BITS = 8,
    parameter int FIFO_AW   = 3,
    parameter int DIV_W     = 10,
    parameter int OVS       = 16
) (
    input  logic      clk,
    input  logic      rst,
`ifdef UART_LOOPBACK_EN
    input  logic      loopback,
`endif
    uart_cfg_if.slave bus,
    input  logic      rx,
    output logic      tx
);
    localparam int CW = $clog2(2*OVS);
    localparam int BW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // ---------------- baud tick ----------------
    logic [DIV_W-1:0] r_baud_cnt;
    logic             w_tick;

    // '>=' also recovers cleanly if baud_div is lowered below the running count.
    assign w_tick = (r_baud_cnt >= bus.baud_div);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_baud_cnt <= '0;
        else if (w_tick) r_baud_cnt <= '0;
        else             r_baud_cnt <= r_baud_cnt + 1'b1;
    end

    // ---------------- pin muxing / synchroniser ----------------
    logic r_tx;
    logic r_rx_s1;
    logic r_rx_s2;
    logic w_rx_src;

`ifdef UART_LOOPBACK_EN
    assign w_rx_src = loopback ? r_tx : rx;
    assign tx       = loopback ? 1'b1 : r_tx;
`else
    assign w_rx_src = rx;
    assign tx       = r_tx;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
        end else begin
            r_rx_s1 <= w_rx_src;
            r_rx_s2 <= r_rx_s1;
        end
    end

    // ---------------- RX engine ----------------
    state_t               r_rx_state;
    logic [CW-1:0]        r_rx_cnt;
    logic [BW-1:0]        r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_par_en;
    logic                 r_rx_odd;
    logic                 r_rx_perr;
    logic                 w_rx_bit_end;
    logic                 w_rx_push;
    logic                 w_rx_full;
    logic [DATA_BITS+1:0] w_rx_head;
    logic                 r_overrun;

    assign w_rx_bit_end = w_tick && (r_rx_cnt == CW'(OVS-1));
    // The push is taken directly off the stop-bit sample so the frame error needs no extra state.
    assign w_rx_push    = (r_rx_state == S_STOP) && w_rx_bit_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_state  <= S_IDLE;
            r_rx_cnt    <= '0;
            r_rx_bit    <= '0;
            r_rx_shift  <= '0;
            r_rx_par_en <= 1'b0;
            r_rx_odd    <= 1'b0;
            r_rx_perr   <= 1'b0;
        end else begin
            case (r_rx_state)
                S_IDLE: begin
                    if (!r_rx_s2) begin
                        r_rx_state  <= S_START;
                        r_rx_cnt    <= '0;
                        r_rx_perr   <= 1'b0;
                        r_rx_par_en <= (bus.parity_mode == 2'b01) || (bus.parity_mode == 2'b10);
                        r_rx_odd    <= (bus.parity_mode == 2'b10);
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_rx_cnt == CW'(OVS/2-1)) begin
                            // Mid start bit: a high line here was only a glitch.
                            r_rx_cnt   <= '0;
                            r_rx_bit   <= '0;
                            r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
                        end else begin
                            r_rx_cnt <= r_rx_cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_rx_bit_end) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_bit == BW'(DATA_BITS-1))
                            r_rx_state <= r_rx_par_en ? S_PARITY : S_STOP;
                        else
                            r_rx_bit <= r_rx_bit + 1'b1;
                    end else if (w_tick) begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_rx_bit_end) begin
                        r_rx_cnt   <= '0;
                        r_rx_perr  <= r_rx_s2 ^ (^r_rx_shift) ^ r_rx_odd;
                        r_rx_state <= S_STOP;
                    end else if (w_tick) begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_rx_bit_end) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= S_IDLE;
                    end else if (w_tick) begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: r_rx_state <= S_IDLE;
            endcase
        end
    end

    uart_cfg_fifo #(.W(DATA_BITS+2), .AW(FIFO_AW)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (w_rx_push),
        .i_din   ({r_rx_perr, !r_rx_s2, r_rx_shift}),
        .o_full  (w_rx_full),
        .i_rd    (bus.read_en),
        .o_dout  (w_rx_head),
        .o_empty (bus.empty),
        .o_level (bus.rx_level)
    );

    assign bus.read_data = w_rx_head[DATA_BITS-1:0];
    assign bus.rx_err    = w_rx_head[DATA_BITS+1:DATA_BITS];

    // A drop in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                         r_overrun <= 1'b0;
        else if (w_rx_push && w_rx_full)  r_overrun <= 1'b1;
        else if (bus.clr_err)             r_overrun <= 1'b0;
    end
    assign bus.overrun = r_overrun;

    // ---------------- TX engine ----------------
    state_t               r_tx_state;
    logic [CW-1:0]        r_tx_cnt;
    logic [BW-1:0]        r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par_en;
    logic                 r_tx_parbit;
    logic                 r_tx_stop2;
    logic                 r_tx_busy;
    logic [DATA_BITS-1:0] w_tx_head;
    logic                 w_tx_empty;
    logic                 w_tx_bit_end;
    logic                 w_tx_stop_end;
    logic                 w_tx_pop;

    assign w_tx_bit_end  = w_tick && (r_tx_cnt == CW'(OVS-1));
    assign w_tx_stop_end = (r_tx_state == S_STOP) && w_tick &&
                           (r_tx_cnt == (r_tx_stop2 ? CW'(2*OVS-1) : CW'(OVS-1)));
    // Popping on the last stop tick lets a queued frame start with no idle cycle in between.
    assign w_tx_pop      = !w_tx_empty && ((r_tx_state == S_IDLE) || w_tx_stop_end);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_state  <= S_IDLE;
            r_tx_cnt    <= '0;
            r_tx_bit    <= '0;
            r_tx_shift  <= '0;
            r_tx_par_en <= 1'b0;
            r_tx_parbit <= 1'b0;
            r_tx_stop2  <= 1'b0;
            r_tx_busy   <= 1'b0;
            r_tx        <= 1'b1;
        end else if (w_tx_pop) begin
            // Frame config is captured here so later changes cannot disturb it.
            r_tx_state  <= S_START;
            r_tx_cnt    <= '0;
            r_tx_shift  <= w_tx_head;
            r_tx_par_en <= (bus.parity_mode == 2'b01) || (bus.parity_mode == 2'b10);
            r_tx_parbit <= (^w_tx_head) ^ (bus.parity_mode == 2'b10);
            r_tx_stop2  <= bus.stop2;
            r_tx_busy   <= 1'b1;
            r_tx        <= 1'b0;
        end else begin
            case (r_tx_state)
                S_START: begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_tx_state <= S_DATA;
                        r_tx       <= r_tx_shift[0];
                    end else if (w_tick) begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == BW'(DATA_BITS-1)) begin
                            r_tx_state <= r_tx_par_en ? S_PARITY : S_STOP;
                            r_tx       <= r_tx_par_en ? r_tx_parbit : 1'b1;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 1'b1;
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx       <= r_tx_shift[1];
                        end
                    end else if (w_tick) begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= S_STOP;
                        r_tx       <= 1'b1;
                    end else if (w_tick) begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_tx_stop_end) begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= S_IDLE;
                        r_tx_busy  <= 1'b0;
                    end else if (w_tick) begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                S_IDLE:  r_tx <= 1'b1;
                default: r_tx_state <= S_IDLE;
            endcase
        end
    end

    assign bus.tx_busy = r_tx_busy;

    uart_cfg_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (bus.write_en),
        .i_din   (bus.write_data),
        .o_full  (bus.full),
        .i_rd    (w_tx_pop),
        .o_dout  (w_tx_head),
        .o_empty (w_tx_empty),
        .o_level (bus.tx_level)
    );
endmodule

// File: tb/tb_uart_cfg.sv
// Bench for uart_cfg: table-driven RX frames, TX waveform checks, FIFO/overrun corner cases, random traffic.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_uart_cfg;
    localparam int DB = 8, AW = 3, DW = 10, OVS = 16, BITCLK = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic tx;

    always #5 clk = ~clk;

    uart_cfg_if #(.DATA_BITS(DB), .FIFO_AW(AW), .DIV_W(DW)) bus ();

    uart_cfg #(.DATA_BITS(DB), .FIFO_AW(AW), .DIV_W(DW), .OVS(OVS)) dut (
        .clk (clk),
        .rst (rst),
`ifdef UART_LOOPBACK_EN
        .loopback (1'b0),
`endif
        .bus (bus),
        .rx  (rx),
        .tx  (tx)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic note_timeout(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    // Reference frame: start 0, data LSB first, optional parity (by bit count), stop bit(s).
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input logic [1:0] pm,
                                               input logic s2, input logic flip, output int nb);
        logic [15:0] v;
        int n, ones;
        v = '0; n = 0; ones = 0;
        v[n] = 1'b0; n++;
        for (int i = 0; i < DB; i++) begin
            v[n] = d[i]; n++;
            ones += int'(d[i]);
        end
        if (pm == 2'd1 || pm == 2'd2) begin
            v[n] = ((pm == 2'd1) ? (ones % 2 == 1) : (ones % 2 == 0)) ^ flip;
            n++;
        end
        v[n] = 1'b1; n++;
        if (s2) begin v[n] = 1'b1; n++; end
        nb = n;
        return v;
    endfunction

    task automatic send_rx(input logic [7:0] d, input logic [1:0] pm, input logic s2,
                           input logic flip, input logic bad_stop);
        logic [15:0] v;
        int nb;
        v = frame_bits(d, pm, s2, flip, nb);
        for (int k = 0; k < nb; k++) begin
            if (bad_stop && k == nb - (s2 ? 2 : 1)) begin
                // Low long enough to cover the stop sample, short enough not to look like a start.
                rx = 1'b0; repeat (12) @(negedge clk);
                rx = 1'b1; repeat (4) @(negedge clk);
            end else begin
                rx = v[k]; repeat (BITCLK) @(negedge clk);
            end
        end
        rx = 1'b1; repeat (BITCLK) @(negedge clk);
    endtask

    task automatic expect_rx(input string nm, input logic [7:0] d, input logic [1:0] e);
        int t = 0;
        while (bus.empty && t < 400) begin @(negedge clk); t++; end
        if (bus.empty) note_timeout(nm);
        else begin
            check({nm, " data"}, 32'(bus.read_data), 32'(d));
            check({nm, " err"}, 32'(bus.rx_err), 32'(e));
            bus.read_en = 1'b1; @(negedge clk); bus.read_en = 1'b0;
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        bus.write_en = 1'b1; bus.write_data = d;
        @(negedge clk);
        bus.write_en = 1'b0;
    endtask

    // Checks tx every cycle of the frame; pm2/s2b are applied mid-frame and must not matter.
    task automatic expect_tx(input string nm, input logic [15:0] v, input int nb,
                             input logic [1:0] pm2, input logic s2b);
        int t = 0;
        int errs = 0;
        while (tx !== 1'b0 && t < 400) begin @(negedge clk); t++; end
        if (tx !== 1'b0) begin note_timeout(nm); return; end
        for (int k = 0; k < nb*BITCLK; k++) begin
            if (k == 20) begin bus.parity_mode = pm2; bus.stop2 = s2b; end
            if (k % BITCLK == BITCLK/2)
                check($sformatf("%s bit%0d", nm, k/BITCLK), 32'(tx), 32'(v[k/BITCLK]));
            else if (tx !== v[k/BITCLK])
                errs++;
            @(negedge clk);
        end
        check({nm, " bit widths"}, 32'(errs), 32'd0);
        check({nm, " idle after frame"}, {30'd0, bus.tx_busy, tx}, 32'b01);
    endtask

    typedef struct {
        logic [7:0] d;
        logic [1:0] pm;
        logic       s2;
        logic       flip;
        logic       bad;
        logic [7:0] ed;
        logic [1:0] ee;
    } rxv_t;

    rxv_t tbl[7];
    logic [7:0] q[$];
    logic       m_ovr;

    initial begin
        logic [15:0] v;
        int nb, t;
        logic [7:0] d;
        logic [1:0] pm, pm2;
        logic s2, flip, bad;

        tbl[0] = '{8'h55, 2'b01, 1'b1, 1'b0, 1'b0, 8'h55, 2'b00};
        tbl[1] = '{8'h55, 2'b01, 1'b1, 1'b1, 1'b0, 8'h55, 2'b10};
        tbl[2] = '{8'h3C, 2'b00, 1'b0, 1'b0, 1'b1, 8'h3C, 2'b01};
        tbl[3] = '{8'hA5, 2'b10, 1'b0, 1'b0, 1'b0, 8'hA5, 2'b00};
        tbl[4] = '{8'h00, 2'b10, 1'b1, 1'b1, 1'b0, 8'h00, 2'b10};
        tbl[5] = '{8'hFF, 2'b11, 1'b0, 1'b1, 1'b0, 8'hFF, 2'b00};
        tbl[6] = '{8'h81, 2'b01, 1'b0, 1'b1, 1'b1, 8'h81, 2'b11};

        bus.baud_div = '0; bus.parity_mode = 2'b00; bus.stop2 = 1'b0;
        bus.write_en = 1'b0; bus.write_data = '0; bus.read_en = 1'b0; bus.clr_err = 1'b0;

        // ---- reset state ----
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst tx", 32'(tx), 32'd1);
        check("rst tx_busy", 32'(bus.tx_busy), 32'd0);
        check("rst full", 32'(bus.full), 32'd0);
        check("rst empty", 32'(bus.empty), 32'd1);
        check("rst tx_level", 32'(bus.tx_level), 32'd0);
        check("rst rx_level", 32'(bus.rx_level), 32'd0);
        check("rst overrun", 32'(bus.overrun), 32'd0);
        check("rst read_data", 32'(bus.read_data), 32'd0);
        check("rst rx_err", 32'(bus.rx_err), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // ---- 8N1 0xA5 waveform: 0,1,0,1,0,0,1,0,1,1 ----
        write_byte(8'hA5);
        expect_tx("a5_8n1", 16'h034A, 10, 2'b00, 1'b0);

        // ---- table-driven RX frames ----
        foreach (tbl[i]) begin
            bus.parity_mode = tbl[i].pm; bus.stop2 = tbl[i].s2;
            send_rx(tbl[i].d, tbl[i].pm, tbl[i].s2, tbl[i].flip, tbl[i].bad);
            expect_rx($sformatf("rxtbl%0d", i), tbl[i].ed, tbl[i].ee);
        end
        check("rx tbl drained", 32'(bus.rx_level), 32'd0);

        // ---- start-bit glitch ----
        bus.parity_mode = 2'b00; bus.stop2 = 1'b0;
        rx = 1'b0; repeat (4) @(negedge clk); rx = 1'b1;
        repeat (60) @(negedge clk);
        check("glitch empty", 32'(bus.empty), 32'd1);
        check("glitch rx_level", 32'(bus.rx_level), 32'd0);

        // ---- overrun: 9 frames, no reads ----
        m_ovr = 1'b0; q.delete();
        for (int i = 0; i < 9; i++) begin
            d = 8'h10 + 8'(i);
            send_rx(d, 2'b00, 1'b0, 1'b0, 1'b0);
            if (q.size() < 2**AW) q.push_back(d); else m_ovr = 1'b1;
        end
        check("ovr rx_level", 32'(bus.rx_level), 32'(q.size()));
        check("ovr flag", 32'(bus.overrun), 32'(m_ovr));
        check("ovr head", 32'(bus.read_data), 32'(q[0]));
        bus.clr_err = 1'b1; @(negedge clk); bus.clr_err = 1'b0;
        check("ovr cleared", 32'(bus.overrun), 32'd0);
        while (q.size() > 0) expect_rx("ovr drain", q.pop_front(), 2'b00);
        check("ovr drained empty", 32'(bus.empty), 32'd1);

        // ---- TX FIFO fill: first word is taken by the engine at once ----
        for (int i = 0; i < 10; i++) write_byte(8'(i));
        check("txf full", 32'(bus.full), 32'd1);
        check("txf level", 32'(bus.tx_level), 32'd8);
        t = 0;
        while (bus.tx_level != 4 && t < 2000) begin @(negedge clk); t++; end
        if (bus.tx_level != 4) note_timeout("txf wait level4");
        else begin
            // Frames are exactly 160 cycles back to back: line up a write with the next pop.
            repeat (159) @(negedge clk);
            check("txf stop before pop", 32'(tx), 32'd1);
            bus.write_en = 1'b1; bus.write_data = 8'hEE;
            @(negedge clk);
            bus.write_en = 1'b0;
            check("txf wr+rd level", 32'(bus.tx_level), 32'd4);
            check("txf no gap tx", 32'(tx), 32'd0);
            check("txf no gap busy", 32'(bus.tx_busy), 32'd1);
        end
        t = 0;
        while ((bus.tx_busy || bus.tx_level != 0) && t < 3000) begin @(negedge clk); t++; end
        if (bus.tx_busy || bus.tx_level != 0) note_timeout("txf drain");
        repeat (4) @(negedge clk);

        // ---- random TX frames, config disturbed mid-frame ----
        for (int i = 0; i < 12; i++) begin
            d = 8'($urandom); pm = 2'($urandom_range(0, 3)); s2 = 1'($urandom_range(0, 1));
            pm2 = 2'($urandom_range(0, 3));
            bus.parity_mode = pm; bus.stop2 = s2;
            v = frame_bits(d, pm, s2, 1'b0, nb);
            write_byte(d);
            expect_tx($sformatf("rtx%0d", i), v, nb, pm2, ~s2);
            repeat (3) @(negedge clk);
        end

        // ---- random RX frames ----
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom); pm = 2'($urandom_range(0, 3)); s2 = 1'($urandom_range(0, 1));
            flip = ($urandom_range(0, 3) == 0); bad = ($urandom_range(0, 3) == 0);
            bus.parity_mode = pm; bus.stop2 = s2;
            send_rx(d, pm, s2, flip, bad);
            expect_rx($sformatf("rrx%0d", i), d, {flip && (pm == 2'd1 || pm == 2'd2), bad});
        end

        // ---- asynchronous reset mid-frame ----
        bus.parity_mode = 2'b00; bus.stop2 = 1'b0;
        send_rx(8'h5A, 2'b00, 1'b0, 1'b0, 1'b0);
        write_byte(8'hC3); write_byte(8'h11); write_byte(8'h22);
        repeat (40) @(negedge clk);
        check("pre-rst busy", 32'(bus.tx_busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst tx", 32'(tx), 32'd1);
        check("arst tx_busy", 32'(bus.tx_busy), 32'd0);
        check("arst tx_level", 32'(bus.tx_level), 32'd0);
        check("arst rx_level", 32'(bus.rx_level), 32'd0);
        check("arst empty", 32'(bus.empty), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("post-rst idle tx", 32'(tx), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_cfg.md
Name: uart_cfg

Overview:
Parametrised successor to the fixed 8N1 UART top. Integrates a baud tick generator, a configurable RX and TX engine, and one RX FIFO and one TX FIFO, with parameterised data width and FIFO depth. Adds runtime parity and stop-bit selection, RX error detection (parity, framing, overrun), and FIFO fill levels. Sits between the host register interface and the serial pins.

Parameters:
DATA_BITS, 8, serial data bits per frame; legal range 5..8.
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW.
DIV_W, 10, baud divisor width.
OVS, 16, oversampling ticks per bit; must be even.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
baud_div  in  DIV_W  tick period = baud_div+1 clocks
parity_mode  in  2  00 none, 01 even, 10 odd, 11 none
stop2  in  1  1 = two stop bits
write_en  in  1  push write_data into TX FIFO
write_data  in  DATA_BITS  TX data
full  out  1  TX FIFO full
tx_level  out  FIFO_AW+1  TX FIFO occupancy
read_en  in  1  pop RX FIFO
read_data  out  DATA_BITS  RX FIFO head (first-word fall-through)
rx_err  out  2  head flags {parity_err, frame_err}
empty  out  1  RX FIFO empty
rx_level  out  FIFO_AW+1  RX FIFO occupancy
overrun  out  1  sticky: RX word dropped because RX FIFO was full
clr_err  in  1  clears overrun
tx_busy  out  1  TX engine not idle
rx  in  1  serial in
tx  out  1  serial out

Behaviour:
- Reset (rst low, async): all counters 0; FSMs IDLE; tx=1; tx_busy=0; full=0; empty=1; levels 0; overrun=0; read_data/rx_err=0; rx synchroniser flops=1.
- Baud: counter 0..baud_div; 1-cycle s_tick when counter==baud_div, then counter returns to 0. baud_div=0 gives s_tick every cycle.
- rx passes through a 2-flop synchroniser before use; it adds 2 cycles of latency.
- RX FSM: IDLE→START on synced rx=0. START: after OVS/2-1 ticks, resample; 0→DATA, 1→IDLE (glitch, nothing pushed). DATA: sample every OVS ticks, LSB first, DATA_BITS samples. PARITY (only if parity enabled): sample, compare with even/odd. STOP: sample 1st stop bit only; 0→frame_err. Then push {parity_err, frame_err, data} and return to IDLE. parity_mode is latched at START entry.
- RX push with FIFO full: word dropped, overrun←1. clr_err clears overrun; a same-cycle drop wins (overrun stays 1).
- TX FSM: IDLE→START when TX FIFO non-empty. It pops the head the same cycle and latches the data, parity_mode and stop2. START drives 0 for OVS ticks. DATA drives LSB first, OVS ticks/bit. PARITY drives even/odd bit if enabled. STOP drives 1 for OVS ticks (2*OVS if stop2). Then IDLE; back-to-back frames begin the cycle after STOP ends.
- tx_busy=1 in every state but IDLE.
- FIFOs: write effective iff write_en && !full; read effective iff read_en && !empty. Simultaneous effective read+write leaves level unchanged. Pointers wrap modulo 2**FIFO_AW. full when level==2**FIFO_AW. Write-when-full and read-when-empty are ignored with no state change.
- read_data/rx_err show the head combinationally from storage; they are valid only when empty=0.
- Config changes mid-frame do not affect the frame in flight.

Optional Feature:
UART_LOOPBACK_EN: when defined, adds input loopback (1 bit). loopback=1 routes internal tx into the RX synchroniser in place of rx, and forces the tx pin to 1. When undefined, the port does not exist and rx is always used.

Test Plan:
- Reset mid-frame: rst low during TX DATA → tx=1, tx_busy=0, levels 0 within the same cycle (async).
- 8N1, baud_div=0: write 0xA5 → tx waveform 0,1,0,1,0,0,1,0,1,1, each bit 16 clk; full frame 160 clk.
- Even parity, stop2, DATA_BITS=7: drive rx frame of 0x55 with parity bit 0 → read_data=0x55, rx_err=00. Repeat with parity bit 1 → rx_err=10.
- Framing: rx stop bit driven 0 with data 0x3C → word pushed, rx_err=01. A 4-tick low glitch on rx → no push.
- Overrun, FIFO_AW=3: receive 9 frames with no reads → rx_level=8, overrun=1, head = 1st word. clr_err → overrun=0.
- TX FIFO: 8 writes → full=1, 9th ignored. Simultaneous write+read at level 4 → level stays 4. Back-to-back frames with no idle gap.
